spi_pixel_slave: RTL
====================

// Module: spi_pixel_slave
// PURPOSE
// SPI mode-0 responder for the klspi host bus. It turns host byte frames into framebuffer pixel writes
// toward the SRAM port, and returns a status byte on MISO. Everything runs in the 50 MHz clk domain;
// SCK/CS/MOSI are oversampled, not used as clocks. It replaces the MISO tie-off and the built-in test
// pattern as the framebuffer's write source.
// PARAMETERS
// ADDR_W    19      pixel address width (SRAM word address)
// DATA_W    16      pixel word width
// ADDR_MAX  416799  last valid address; burst increment wraps to 0 after this
// PORTS
// clk        in   1       50 MHz system clock
// rst_n      in   1       asynchronous active-low reset
// spi_cs     in   1       host chip select, active low, async to clk
// spi_sck    in   1       host SPI clock (mode 0), max clk/8, async
// spi_mosi   in   1       host data in, MSB first
// spi_miso   out  1       data to host, MSB first
// miso_oe    out  1       1 = drive spi_miso (top tristates when 0)
// wr_valid   out  1       pixel write request pending
// wr_addr    out  ADDR_W  pixel address of pending request
// wr_data    out  DATA_W  pixel value of pending request
// wr_ready   in   1       SRAM side accepts request this cycle
// busy       out  1       frame in progress (CS low, synchronized)
// BEHAVIOUR
// - Reset (async, rst_n=0): every flop cleared; state IDLE; wr_valid=0; wr_addr=0; wr_data=0;
//   miso_oe=0; spi_miso=0; busy=0; overflow flag=0.
// - Sync: 2-flop synchronizer on cs, sck, mosi; a third stage feeds the edge detectors.
//   A rise = sampling edge (shift MOSI in); a fall = MISO launch edge.
// - Bits are counted modulo 8 per byte; a byte completes on the 8th rise.
// - Frame starts on the sync CS fall: state CMD, bit counter 0, miso_oe=1, busy=1.
// - States:
//   IDLE
//   CMD: byte 0x02 -> ADDR; 0x05 -> STAT; any other value -> IGNORE.
//   ADDR: 3 bytes, big-endian; low ADDR_W bits kept; then -> DATA.
//   DATA: 2 bytes, big-endian, form one word; the state stays DATA (burst).
//   STAT: following bytes return the status byte.
//   IGNORE: MOSI discarded and MISO=0 until CS high.
// - Completing a DATA word: if wr_valid=0, or wr_ready=1 in the same cycle, load wr_addr/wr_data and set
//   wr_valid=1 on the next clk. The internal address then increments; ADDR_MAX+1 wraps to 0.
//   Otherwise the word is dropped, ovf is set (sticky), and the address still increments.
// - wr_valid: asserts 1 clk after the internal completing rise (<=4 clk after the pin edge).
//   It is held with addr/data stable until a clk with wr_ready=1, then clears next clk unless reloaded.
// - MISO: status byte = {wr_valid, ovf, 4'b0000, 2'b10}. It is shifted out MSB first during the CMD byte
//   and during every STAT-state byte. The MSB is presented on CS fall; the next bit is presented on each
//   SCK fall. In ADDR/DATA/IGNORE, MISO=0.
// - CS rise (sync) at any point: a partial byte or partial word is discarded; state -> IDLE; miso_oe=0;
//   busy=0. A completed pending request is kept until accepted. If the frame was a STAT frame with
//   at least one full status byte sent, ovf clears.
// - CS rise and SCK rise resolving in the same clk: CS wins, and the bit is ignored.
// - Reset mid-frame or mid-request: the request is lost; the host must re-send after reset.
// TESTING
// 1. Write frame: CS low, 02 00 25 80 01 5E, CS high, wr_ready=1 -> a single wr_valid pulse with
//    addr=0x02580 (9600), data=0x015E (350).
// 2. Burst: 02 00 00 00 then 3 words AAAA BBBB CCCC -> three requests, addr 0/1/2 in order.
//    Start address 416799 with 2 words -> addr 416799, then 0.
// 3. Backpressure: wr_ready=0, burst 2 words -> the first is held stable and the second is dropped.
//    Then STAT frame 05 00 -> MISO reads 0xC2 on byte 0 and 0xC2 on byte 1.
//    After CS high, a new STAT frame reads 0x82.
// 4. Abort: 02 00 10 then 4 bits, CS high -> no request, busy=0, miso_oe=0.
//    A following valid frame writes correctly.
// 5. Unknown cmd 0x7F followed by 4 bytes -> no request and MISO=0 after the CMD byte.
// 6. rst_n low mid-DATA with wr_valid=1 -> all outputs 0 immediately (async); after release, IDLE
//    and a fresh frame works.

Source files
------------

// File: rtl/spi_pixel_slave_if.sv
// Host SPI pins plus the framebuffer write-request port of spi_pixel_slave.
// The slave modport is the SPI responder; the master modport is the host/SRAM side.
interface spi_pixel_slave_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
);
    logic              spi_cs;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic              miso_oe;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              busy;

    modport slave (
        input  spi_cs, spi_sck, spi_mosi, wr_ready,
        output spi_miso, miso_oe, wr_valid, wr_addr, wr_data, busy
    );

    modport master (
        output spi_cs, spi_sck, spi_mosi, wr_ready,
        input  spi_miso, miso_oe, wr_valid, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/spi_pixel_slave.sv
// SPI mode-0 pixel write slave: oversampled host frames become framebuffer write requests,
// and a status byte {wr_valid, ovf, 4'b0000, 2'b10} is shifted back on MISO.
module spi_pixel_slave #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 16,
    parameter int ADDR_MAX = 416799
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_pixel_slave_if.slave bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_STAT   = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    localparam logic [7:0]        CMD_WRITE = 8'h02;
    localparam logic [7:0]        CMD_STAT  = 8'h05;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_MAX);

    logic              cs_p0, cs_p1, cs_p2;
    logic              sck_p0, sck_p1, sck_p2;
    logic              mosi_p0, mosi_p1;
    logic [2:0]        state;
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_idx;
    logic [6:0]        rx_sr;
    logic [15:0]       addr_sh;
    logic [7:0]        data_hi;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        tx_sr;
    logic              miso_q;
    logic              stat_sent;
    logic              ovf;
    logic              wr_valid_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic              cs_rise, cs_fall, sck_rise, sck_fall;
    logic              in_frame, byte_done, word_done, accept;
    logic [7:0]        rx_byte;
    logic [7:0]        status;
    logic [ADDR_W-1:0] ptr_next;

    // Stage p0/p1: two-flop synchronizers; stage p2: edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_p0   <= 1'b0;
            cs_p1   <= 1'b0;
            cs_p2   <= 1'b0;
            sck_p0  <= 1'b0;
            sck_p1  <= 1'b0;
            sck_p2  <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            cs_p0   <= bus.spi_cs;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            sck_p0  <= bus.spi_sck;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            mosi_p0 <= bus.spi_mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign cs_rise   = cs_p1 & ~cs_p2;
    assign cs_fall   = ~cs_p1 & cs_p2;
    assign sck_rise  = sck_p1 & ~sck_p2;
    assign sck_fall  = ~sck_p1 & sck_p2;
    assign in_frame  = (state != ST_IDLE);
    assign rx_byte   = {rx_sr, mosi_p1};
    assign status    = {wr_valid_q, ovf, 4'b0000, 2'b10};
    // A CS rise in the same clk as the 8th SCK rise wins and drops that bit
    assign byte_done = in_frame && sck_rise && !cs_rise && (bit_cnt == 3'd7);
    assign word_done = byte_done && (state == ST_DATA) && (byte_idx == 2'd1);
    assign accept    = !wr_valid_q || bus.wr_ready;
    assign ptr_next  = (ptr == ADDR_LAST) ? '0 : ptr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            byte_idx  <= 2'd0;
            rx_sr     <= 7'd0;
            addr_sh   <= 16'd0;
            data_hi   <= 8'd0;
            ptr       <= '0;
            tx_sr     <= 8'd0;
            miso_q    <= 1'b0;
            stat_sent <= 1'b0;
        end else if (cs_rise) begin
            state <= ST_IDLE;
        end else if (cs_fall) begin
            state     <= ST_CMD;
            bit_cnt   <= 3'd0;
            byte_idx  <= 2'd0;
            stat_sent <= 1'b0;
            miso_q    <= status[7];
            tx_sr     <= {status[6:0], 1'b0};
        end else if (in_frame && sck_rise) begin
            rx_sr   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
                case (state)
                    ST_CMD: begin
                        byte_idx <= 2'd0;
                        if (rx_byte == CMD_WRITE)     state <= ST_ADDR;
                        else if (rx_byte == CMD_STAT) state <= ST_STAT;
                        else                          state <= ST_IGNORE;
                    end
                    ST_ADDR: begin
                        addr_sh <= {addr_sh[7:0], rx_byte};
                        if (byte_idx == 2'd2) begin
                            ptr      <= ADDR_W'({addr_sh, rx_byte});
                            byte_idx <= 2'd0;
                            state    <= ST_DATA;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                    ST_DATA: begin
                        if (byte_idx == 2'd0) begin
                            data_hi  <= rx_byte;
                            byte_idx <= 2'd1;
                        end else begin
                            byte_idx <= 2'd0;
                            ptr      <= ptr_next;
                        end
                    end
                    ST_STAT: stat_sent <= 1'b1;
                    default: ;
                endcase
            end
        end else if (in_frame && sck_fall) begin
            // bit_cnt wraps to 0 after a full byte, so the next fall starts a fresh status byte
            if (bit_cnt == 3'd0) begin
                miso_q <= status[7];
                tx_sr  <= {status[6:0], 1'b0};
            end else begin
                miso_q <= tx_sr[7];
                tx_sr  <= {tx_sr[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else if (word_done && accept) begin
            wr_valid_q <= 1'b1;
            wr_addr_q  <= ptr;
            wr_data_q  <= DATA_W'({data_hi, rx_byte});
        end else if (wr_valid_q && bus.wr_ready) begin
            wr_valid_q <= 1'b0;
        end
    end

    // Overflow is sticky until the host has read at least one full status byte in a STAT frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (word_done && !accept) begin
            ovf <= 1'b1;
        end else if (cs_rise && (state == ST_STAT) && stat_sent) begin
            ovf <= 1'b0;
        end
    end

    assign bus.spi_miso = miso_q && ((state == ST_CMD) || (state == ST_STAT));
    assign bus.miso_oe  = in_frame;
    assign bus.busy     = in_frame;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
endmodule
